// File: rtl/ctrl_multiciclo.sv
// Multicycle control FSM for an RV64I subset (ALU-imm, ALU-reg, load, store, branch).
// Optional macro CTRL_ILLEGAL_TRAP_EN adds a sticky TRAP state and the illegal_o flag.
module ctrl_multiciclo (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic       zero_i,
  input  logic       mem_ack_i,
  output logic       mem_req_o,
  output logic       mem_we_o,
  output logic       addr_sel_o,
  output logic       ir_we_o,
  output logic       pc_we_o,
  output logic       pc_src_o,
  output logic       alu_src_o,
  output logic [1:0] alu_op_o,
  output logic       reg_we_o,
  output logic       wb_sel_o,
`ifdef CTRL_ILLEGAL_TRAP_EN
  output logic       illegal_o,
`endif
  output logic [3:0] state_o
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    EXEC   = 4'd3,
    ADDR   = 4'd4,
    MEM    = 4'd5,
    WB     = 4'd6,
    BRANCH = 4'd7,
    TRAP   = 4'd8
  } state_e;

  state_e state_q, state_d;
  logic   is_store;
  logic   br_taken;

  assign is_store = (opcode_i == OP_STORE);
  assign br_taken = ((funct3_i == 3'b000) && zero_i) || ((funct3_i == 3'b001) && !zero_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    addr_sel_o = 1'b0;
    ir_we_o    = 1'b0;
    pc_we_o    = 1'b0;
    pc_src_o   = 1'b0;
    alu_src_o  = 1'b0;
    alu_op_o   = 2'b00;
    reg_we_o   = 1'b0;
    wb_sel_o   = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
    illegal_o  = 1'b0;
`endif
    case (state_q)
      IDLE: state_d = FETCH;
      FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ack_i) begin
          ir_we_o = 1'b1;
          pc_we_o = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        case (opcode_i)
          OP_IMM, OP_REG:    state_d = EXEC;
          OP_LOAD, OP_STORE: state_d = ADDR;
          OP_BRANCH:         state_d = BRANCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
          default:           state_d = TRAP;
`else
          default:           state_d = FETCH;
`endif
        endcase
      end
      EXEC: begin
        alu_op_o  = 2'b10;
        alu_src_o = (opcode_i == OP_IMM);
        state_d   = WB;
      end
      ADDR: begin
        alu_src_o = 1'b1;
        state_d   = MEM;
      end
      MEM: begin
        // Request, direction and address select stay fixed while waiting for ack.
        mem_req_o  = 1'b1;
        addr_sel_o = 1'b1;
        alu_src_o  = 1'b1;
        mem_we_o   = is_store;
        if (mem_ack_i) state_d = is_store ? FETCH : WB;
      end
      WB: begin
        reg_we_o = 1'b1;
        wb_sel_o = (opcode_i == OP_LOAD);
        state_d  = FETCH;
      end
      BRANCH: begin
        alu_op_o = 2'b01;
        if (br_taken) begin
          pc_we_o  = 1'b1;
          pc_src_o = 1'b1;
        end
        state_d = FETCH;
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      TRAP: illegal_o = 1'b1;
`endif
      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;

endmodule

// File: tb/tb_ctrl_multiciclo.sv
// Scoreboard bench for ctrl_multiciclo: instruction-level reference model pushes per-cycle
// expectations; a negedge monitor pops and compares state and control outputs.
module tb_ctrl_multiciclo;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [3:0] S_IDLE = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_EXEC = 4'd3,
                         S_ADDR = 4'd4, S_MEM = 4'd5, S_WB = 4'd6, S_BRANCH = 4'd7,
                         S_TRAP = 4'd8;

  logic       clk_i = 1'b0;
  logic       rst_ni = 1'b0;
  logic [6:0] opcode_i = '0;
  logic [2:0] funct3_i = '0;
  logic       zero_i = 1'b0;
  logic       mem_ack_i = 1'b0;
  logic       mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o, pc_src_o;
  logic       alu_src_o, reg_we_o, wb_sel_o;
  logic [1:0] alu_op_o;
  logic [3:0] state_o;
`ifdef CTRL_ILLEGAL_TRAP_EN
  logic       illegal_o;
`endif

  ctrl_multiciclo dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .zero_i(zero_i), .mem_ack_i(mem_ack_i), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
    .addr_sel_o(addr_sel_o), .ir_we_o(ir_we_o), .pc_we_o(pc_we_o), .pc_src_o(pc_src_o),
    .alu_src_o(alu_src_o), .alu_op_o(alu_op_o), .reg_we_o(reg_we_o), .wb_sel_o(wb_sel_o),
`ifdef CTRL_ILLEGAL_TRAP_EN
    .illegal_o(illegal_o),
`endif
    .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [3:0]  st;
    logic [10:0] o;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Output vector order: mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src, alu_op[1:0], reg_we, wb_sel
  function automatic logic [10:0] exp_out(input logic [3:0] st, input logic [6:0] opc,
                                          input logic [2:0] f3, input logic z, input logic ack);
    logic [10:0] v;
    v = '0;
    case (st)
      S_FETCH:  v = ack ? 11'b100_110_0_00_00 : 11'b100_000_0_00_00;
      S_EXEC:   v = (opc == OP_IMM) ? 11'b000_000_1_10_00 : 11'b000_000_0_10_00;
      S_ADDR:   v = 11'b000_000_1_00_00;
      S_MEM:    v = (opc == OP_STORE) ? 11'b111_000_1_00_00 : 11'b101_000_1_00_00;
      S_WB:     v = (opc == OP_LOAD) ? 11'b000_000_0_00_11 : 11'b000_000_0_00_10;
      S_BRANCH: v = (((f3 == 3'd0) && z) || ((f3 == 3'd1) && !z)) ? 11'b000_011_0_01_00
                                                                  : 11'b000_000_0_01_00;
      default:  v = '0;
    endcase
    return v;
  endfunction

  function automatic bit is_legal(input logic [6:0] opc);
    return (opc == OP_IMM) || (opc == OP_REG) || (opc == OP_LOAD) ||
           (opc == OP_STORE) || (opc == OP_BRANCH);
  endfunction

  task automatic step(input logic [3:0] st, input logic [6:0] opc, input logic [2:0] f3,
                      input logic z, input logic ack);
    exp_t e;
    @(posedge clk_i); #1;
    opcode_i  = opc;
    funct3_i  = f3;
    zero_i    = z;
    mem_ack_i = ack;
    e.st = st;
    e.o  = exp_out(st, opc, f3, z, ack);
    q.push_back(e);
  endtask

  task automatic reset_seq(input int n);
    exp_t e;
    e = '0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i); #1;
      rst_ni = 1'b0;
      mem_ack_i = 1'($urandom_range(0, 1));
      q.push_back(e);
    end
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    mem_ack_i = 1'b0;
    q.push_back(e);
  endtask

  // One instruction from FETCH onward; zb < 0 means zero_i random in BRANCH.
  task automatic run_instr(input logic [6:0] opc, input logic [2:0] f3, input int fd,
                           input int md, input int zb);
    logic z;
    for (int i = 0; i < fd; i++) step(S_FETCH, opc, f3, 1'($urandom_range(0, 1)), 1'b0);
    step(S_FETCH, opc, f3, 1'($urandom_range(0, 1)), 1'b1);
    step(S_DECODE, opc, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    if (opc == OP_IMM || opc == OP_REG) begin
      step(S_EXEC, opc, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      step(S_WB, opc, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end else if (opc == OP_LOAD || opc == OP_STORE) begin
      step(S_ADDR, opc, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      for (int i = 0; i < md; i++) step(S_MEM, opc, f3, 1'($urandom_range(0, 1)), 1'b0);
      step(S_MEM, opc, f3, 1'($urandom_range(0, 1)), 1'b1);
      if (opc == OP_LOAD) step(S_WB, opc, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end else if (opc == OP_BRANCH) begin
      z = (zb < 0) ? 1'($urandom_range(0, 1)) : 1'(zb);
      step(S_BRANCH, opc, f3, z, 1'($urandom_range(0, 1)));
    end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      for (int i = 0; i < 10; i++) step(S_TRAP, opc, f3, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      reset_seq(2);
`endif
    end
  endtask

  // Assert reset between edges in the middle of a stalled load access.
  task automatic mid_mem_reset();
    exp_t e;
    step(S_FETCH, OP_LOAD, 3'd0, 1'b0, 1'b1);
    step(S_DECODE, OP_LOAD, 3'd0, 1'b0, 1'b0);
    step(S_ADDR, OP_LOAD, 3'd0, 1'b0, 1'b0);
    step(S_MEM, OP_LOAD, 3'd0, 1'b0, 1'b0);
    step(S_MEM, OP_LOAD, 3'd0, 1'b0, 1'b0);
    @(posedge clk_i); #1;
    rst_ni = 1'b0;
    #1;
    n_vec++;
    if (state_o !== 4'd0 || mem_req_o !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset_mid_mem: state_o=%0d mem_req_o=%b, want state 0 mem_req 0",
               state_o, mem_req_o);
    end
    e = '0;
    q.push_back(e);
    reset_seq(2);
  endtask

  always @(negedge clk_i) begin
    exp_t e;
    logic [10:0] act;
    if (q.size() > 0) begin
      e = q.pop_front();
      act = {mem_req_o, mem_we_o, addr_sel_o, ir_we_o, pc_we_o, pc_src_o, alu_src_o,
             alu_op_o, reg_we_o, wb_sel_o};
      n_vec++;
      if (state_o !== e.st || act !== e.o) begin
        n_err++;
        $display("FAIL cycle_check t=%0t: state=%0d outs=%b, want state=%0d outs=%b",
                 $time, state_o, act, e.st, e.o);
      end
`ifdef CTRL_ILLEGAL_TRAP_EN
      if (illegal_o !== (e.st == S_TRAP)) begin
        n_err++;
        $display("FAIL illegal_flag t=%0t: illegal_o=%b, want %b", $time, illegal_o, e.st == S_TRAP);
      end
`endif
    end
  end

  initial begin
    logic [6:0] opc;
    int k;
    reset_seq(3);
    run_instr(OP_IMM, 3'($urandom_range(0, 7)), 0, 0, -1);
    run_instr(OP_LOAD, 3'd3, 0, 3, -1);
    run_instr(OP_STORE, 3'd3, 1, 0, -1);
    run_instr(OP_REG, 3'd0, 2, 0, -1);
    run_instr(OP_BRANCH, 3'd0, 0, 0, 1);
    run_instr(OP_BRANCH, 3'd1, 0, 0, 1);
    run_instr(OP_BRANCH, 3'd1, 0, 0, 0);
    run_instr(OP_BRANCH, 3'd0, 0, 0, 0);
    run_instr(7'b1111111, 3'd0, 0, 0, -1);
    run_instr(OP_STORE, 3'd2, 0, 2, -1);
    mid_mem_reset();
    for (int n = 0; n < 80; n++) begin
      k = $urandom_range(0, 5);
      case (k)
        0: opc = OP_IMM;
        1: opc = OP_REG;
        2: opc = OP_LOAD;
        3: opc = OP_STORE;
        4: opc = OP_BRANCH;
        default: begin
          opc = 7'($urandom);
          while (is_legal(opc)) opc = 7'($urandom);
        end
      endcase
      run_instr(opc, 3'($urandom_range(0, 7)), $urandom_range(0, 3), $urandom_range(0, 3), -1);
      if ($urandom_range(0, 15) == 0) reset_seq(1);
    end
    repeat (2) @(posedge clk_i);
    n_vec++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
